// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
// Shared types and helpers for the asynchronous FIFO pointer logic.
//   - ptr_width()  : pointer width including the wrap bit for a given depth
//   - bin2gray()   : binary to reflected Gray code
//   - gray2bin()   : reflected Gray code to binary
//   - deq_state_e  : dequeue-side output register state
// Helpers operate on 32-bit values; callers zero-extend narrower pointers and
// truncate the result, which is exact for both conversions.
// -----------------------------------------------------------------------------
package async_fifo_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        VALID = 1'b1
    } deq_state_e;

    function automatic int ptr_width(input int num_entries);
        return $clog2(num_entries) + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin_val);
        return bin_val ^ (bin_val >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray_val);
        logic [31:0] bin_val;
        bin_val = gray_val;
        for (int i = 30; i >= 0; i--) begin
            bin_val[i] = bin_val[i + 1] ^ gray_val[i];
        end
        return bin_val;
    endfunction

endpackage

// File: rtl/read_ptr_deq_blk_if.sv
// -----------------------------------------------------------------------------
// read_ptr_deq_blk_if
// Valid/ready dequeue channel of the async FIFO read side.
//   deq_val : producer -> consumer, output entry valid
//   deq_rdy : consumer -> producer, consumer accepts this cycle
//   deq_msg : producer -> consumer, output entry payload
// Modports: master = FIFO read side (drives val/msg), slave = consumer.
// -----------------------------------------------------------------------------
interface read_ptr_deq_blk_if #(
    parameter int p_bit_width = 32
);

    logic                   deq_val;
    logic                   deq_rdy;
    logic [p_bit_width-1:0] deq_msg;

    modport master (
        output deq_val,
        output deq_msg,
        input  deq_rdy
    );

    modport slave (
        input  deq_val,
        input  deq_msg,
        output deq_rdy
    );

endinterface

// File: rtl/read_ptr_deq_blk_gray_to_bin.sv
// -----------------------------------------------------------------------------
// gray_to_bin
// Purely combinational reflected-Gray to binary converter.
//   gray : Gray-coded input  [p_bit_width-1:0]
//   bin  : binary output     [p_bit_width-1:0]
// Each binary bit is the XOR of all Gray bits at or above it, so the chain
// is evaluated MSB first.
// -----------------------------------------------------------------------------
module gray_to_bin #(
    parameter int p_bit_width = 4
) (
    input  logic [p_bit_width-1:0] gray,
    output logic [p_bit_width-1:0] bin
);

    // MSB-first XOR prefix chain
    always_comb begin
        bin = gray;
        for (int i = p_bit_width - 2; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
    end

endmodule

// File: rtl/read_ptr_deq_blk.sv
// -----------------------------------------------------------------------------
// read_ptr_deq_blk
// Read-domain half of the asynchronous FIFO. Synchronizes the Gray write
// pointer, derives empty, owns the binary/Gray read pointers and prefetches the
// storage word into an output register presented on a valid/ready channel.
//
// Ports:
//   clk               in   read-domain clock
//   reset             in   asynchronous, active-high reset
//   g_write_ptr_async in   Gray write pointer from the write clock domain
//   b_read_ptr        out  binary read pointer; low bits address storage
//   g_read_ptr        out  registered Gray read pointer for the write side
//   r_data            in   storage word at b_read_ptr (combinational read)
//   rd_count          out  conservative occupancy (ASYNC_FIFO_RD_OCC_EN only)
//   deq               if   master side of the dequeue channel
//
// Optional feature macro: ASYNC_FIFO_RD_OCC_EN adds the rd_count output.
// -----------------------------------------------------------------------------
module read_ptr_deq_blk
    import async_fifo_pkg::*;
#(
    parameter int p_num_entries = 8,
    parameter int p_bit_width   = 32,
    parameter int p_ptr_width   = ptr_width(p_num_entries)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [p_ptr_width-1:0] g_write_ptr_async,
    output logic [p_ptr_width-1:0] b_read_ptr,
    output logic [p_ptr_width-1:0] g_read_ptr,
    input  logic [p_bit_width-1:0] r_data,
`ifdef ASYNC_FIFO_RD_OCC_EN
    output logic [p_ptr_width-1:0] rd_count,
`endif
    read_ptr_deq_blk_if.master     deq
);

    logic [p_ptr_width-1:0] g_wp_meta_r;
    logic [p_ptr_width-1:0] g_wp_sync_r;

    deq_state_e             state_r;
    deq_state_e             state_nxt_s;

    logic [p_ptr_width-1:0] b_read_ptr_r;
    logic [p_ptr_width-1:0] b_read_ptr_nxt_s;
    logic [p_ptr_width-1:0] g_read_ptr_r;
    logic [p_ptr_width-1:0] g_read_ptr_nxt_s;

    logic [p_bit_width-1:0] deq_msg_r;

    logic                   empty_s;
    logic                   fetch_s;

    // Two-flop synchronizer; the async input feeds nothing but the first stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g_wp_meta_r <= {p_ptr_width{1'b0}};
            g_wp_sync_r <= {p_ptr_width{1'b0}};
        end else begin
            g_wp_meta_r <= g_write_ptr_async;
            g_wp_sync_r <= g_wp_meta_r;
        end
    end

    // Empty detect, fetch decision, next state and next pointers.
    // A fetch in VALID with deq_rdy replaces the accepted word in the same
    // cycle, so the output stays valid with no bubble.
    always_comb begin
        empty_s          = (g_read_ptr_r == g_wp_sync_r);
        fetch_s          = !empty_s && ((state_r == IDLE) || deq.deq_rdy);
        state_nxt_s      = state_r;
        b_read_ptr_nxt_s = b_read_ptr_r;
        if (fetch_s) begin
            state_nxt_s      = VALID;
            b_read_ptr_nxt_s = b_read_ptr_r + p_ptr_width'(1'b1);
        end else if ((state_r == VALID) && deq.deq_rdy) begin
            state_nxt_s = IDLE;
        end else begin
            state_nxt_s = state_r;
        end
        g_read_ptr_nxt_s = p_ptr_width'(bin2gray(32'(b_read_ptr_nxt_s)));
    end

    // Output register state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Binary and Gray read pointers, updated together so the Gray copy is
    // always the exact encoding of the binary one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_read_ptr_r <= {p_ptr_width{1'b0}};
            g_read_ptr_r <= {p_ptr_width{1'b0}};
        end else begin
            b_read_ptr_r <= b_read_ptr_nxt_s;
            g_read_ptr_r <= g_read_ptr_nxt_s;
        end
    end

    // Prefetch register; holds while stalled so deq_msg is stable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deq_msg_r <= {p_bit_width{1'b0}};
        end else if (fetch_s) begin
            deq_msg_r <= r_data;
        end else begin
            deq_msg_r <= deq_msg_r;
        end
    end

    assign b_read_ptr  = b_read_ptr_r;
    assign g_read_ptr  = g_read_ptr_r;
    assign deq.deq_val = (state_r == VALID);
    assign deq.deq_msg = deq_msg_r;

`ifdef ASYNC_FIFO_RD_OCC_EN
    logic [p_ptr_width-1:0] b_wp_sync_s;
    logic [p_ptr_width-1:0] occ_nxt_s;
    logic [p_ptr_width-1:0] rd_count_r;

    gray_to_bin #(
        .p_bit_width (p_ptr_width)
    ) u_wp_gray_to_bin (
        .gray (g_wp_sync_r),
        .bin  (b_wp_sync_s)
    );

    // Occupancy from the post-edge read state: read-side changes are counted
    // exactly, the synchronized write pointer only lags, so the count never
    // overstates what is really held
    always_comb begin
        occ_nxt_s = (b_wp_sync_s - b_read_ptr_nxt_s)
                  + ((state_nxt_s == VALID) ? p_ptr_width'(1'b1) : {p_ptr_width{1'b0}});
    end

    // Registered occupancy output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count_r <= {p_ptr_width{1'b0}};
        end else begin
            rd_count_r <= occ_nxt_s;
        end
    end

    assign rd_count = rd_count_r;
`endif

endmodule

// File: tb/tb_read_ptr_deq_blk.sv
// -----------------------------------------------------------------------------
// tb_read_ptr_deq_blk
// Directed bench for read_ptr_deq_blk (depth 8, 32-bit payload, 4-bit ptrs).
// Stimulus writes a storage model and pushes each written word into exp_q; a
// negedge monitor compares deq_msg against the queue head whenever deq_val is
// high and pops on acceptance. Occupancy checks compile under
// ASYNC_FIFO_RD_OCC_EN.
// -----------------------------------------------------------------------------
module tb_read_ptr_deq_blk;

    logic        clk;
    logic        reset;
    logic [3:0]  g_write_ptr_async;
    logic [3:0]  b_read_ptr;
    logic [3:0]  g_read_ptr;
    logic [31:0] r_data;
`ifdef ASYNC_FIFO_RD_OCC_EN
    logic [3:0]  rd_count;
`endif

    logic [31:0] mem [8];
    logic [31:0] exp_q [$];
    logic [3:0]  wptr_bin;

    int checks   = 0;
    int failures = 0;

    read_ptr_deq_blk_if #(.p_bit_width(32)) deq_if ();

    read_ptr_deq_blk #(
        .p_num_entries (8),
        .p_bit_width   (32)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .g_write_ptr_async (g_write_ptr_async),
        .b_read_ptr        (b_read_ptr),
        .g_read_ptr        (g_read_ptr),
        .r_data            (r_data),
`ifdef ASYNC_FIFO_RD_OCC_EN
        .rd_count          (rd_count),
`endif
        .deq               (deq_if.master)
    );

    assign r_data = mem[b_read_ptr[2:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] gray4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    // write one word into storage, advance the write pointer, expect it later
    task automatic push_entry(input logic [31:0] data);
        mem[wptr_bin[2:0]] = data;
        exp_q.push_back(data);
        wptr_bin          = wptr_bin + 4'd1;
        g_write_ptr_async = gray4(wptr_bin);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // consume everything and confirm the FIFO goes empty
    task automatic drain(input string name);
        int n;
        deq_if.deq_rdy = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || deq_if.deq_val) && n < 60) begin
            step();
            n++;
        end
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({name, "_val_low"}, 32'(deq_if.deq_val), 32'd0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset && deq_if.deq_val) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got %h expected no beat", deq_if.deq_msg);
            end else begin
                check("deq_msg", deq_if.deq_msg, exp_q[0]);
                if (deq_if.deq_rdy) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [3:0] prev_b;
        logic [3:0] prev_g;
        int         written;
        int         n;
        logic       saw_wrap;

        reset             = 1'b1;
        deq_if.deq_rdy    = 1'b0;
        wptr_bin          = 4'd0;
        g_write_ptr_async = 4'd0;
        for (int i = 0; i < 8; i++) mem[i] = 32'd0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // idle after reset
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_val", 32'(deq_if.deq_val), 32'd0);
            check("idle_bptr", 32'(b_read_ptr), 32'd0);
            check("idle_gptr", 32'(g_read_ptr), 32'd0);
        end

        // single entry, latency of three edges
        deq_if.deq_rdy = 1'b1;
        push_entry(32'hA5A5_0001);
        step();
        check("lat_edge1_val", 32'(deq_if.deq_val), 32'd0);
        step();
        check("lat_edge2_val", 32'(deq_if.deq_val), 32'd0);
        step();
        check("lat_edge3_val", 32'(deq_if.deq_val), 32'd1);
        check("single_msg", deq_if.deq_msg, 32'hA5A5_0001);
        check("single_bptr", 32'(b_read_ptr), 32'd1);
        check("single_gptr", 32'(g_read_ptr), 32'b0001);
        step();
        check("single_fall_val", 32'(deq_if.deq_val), 32'd0);

        // stall: one prefetch only, then stream with no bubble
        deq_if.deq_rdy = 1'b0;
        for (int i = 2; i <= 8; i++) push_entry(32'hA5A5_0000 + 32'(i));
        check("stall_wptr_gray", 32'(g_write_ptr_async), 32'b1100);
        repeat (5) step();
        check("stall_one_prefetch_bptr", 32'(b_read_ptr), 32'd2);
        check("stall_val", 32'(deq_if.deq_val), 32'd1);
        check("stall_msg", deq_if.deq_msg, 32'hA5A5_0002);
        deq_if.deq_rdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check("stream_no_bubble", 32'(deq_if.deq_val), 32'd1);
            step();
        end
        check("stream_end_val", 32'(deq_if.deq_val), 32'd0);
        check("stream_end_bptr", 32'(b_read_ptr), 32'd8);
        check("stream_end_gptr", 32'(g_read_ptr), 32'b1100);

        // wrap-around: 20 entries streamed through the 8-deep storage
        written  = 0;
        saw_wrap = 1'b0;
        prev_b   = b_read_ptr;
        prev_g   = g_read_ptr;
        n        = 0;
        while (!(written == 20 && exp_q.size() == 0 && !deq_if.deq_val) && n < 300) begin
            if (written < 20 && 4'(wptr_bin - b_read_ptr) < 4'd8) begin
                push_entry(32'hC0DE_0000 + 32'(written));
                written++;
            end
            step();
            n++;
            if (prev_b == 4'd15 && b_read_ptr == 4'd0) begin
                saw_wrap = 1'b1;
                check("wrap_gptr_before", 32'(prev_g), 32'b1000);
                check("wrap_gptr_after", 32'(g_read_ptr), 32'b0000);
            end
            prev_b = b_read_ptr;
            prev_g = g_read_ptr;
        end
        check("wrap_all_written", 32'(written), 32'd20);
        check("wrap_seen", 32'(saw_wrap), 32'd1);
        check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);
        check("wrap_end_bptr", 32'(b_read_ptr), 32'd12);
        check("wrap_end_gptr", 32'(g_read_ptr), 32'b1010);
        check("wrap_end_val", 32'(deq_if.deq_val), 32'd0);

        // reset mid-stream with a valid word held
        deq_if.deq_rdy = 1'b0;
        for (int i = 0; i < 3; i++) push_entry(32'hDEAD_0000 + 32'(i));
        n = 0;
        while (!deq_if.deq_val && n < 10) begin
            step();
            n++;
        end
        check("pre_reset_val", 32'(deq_if.deq_val), 32'd1);
        #1;
        reset             = 1'b1;
        wptr_bin          = 4'd0;
        g_write_ptr_async = 4'd0;
        exp_q.delete();
        #1;
        check("async_reset_val", 32'(deq_if.deq_val), 32'd0);
        check("async_reset_msg", deq_if.deq_msg, 32'd0);
        check("async_reset_bptr", 32'(b_read_ptr), 32'd0);
        check("async_reset_gptr", 32'(g_read_ptr), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("post_reset_val", 32'(deq_if.deq_val), 32'd0);
        end

`ifdef ASYNC_FIFO_RD_OCC_EN
        // occupancy: 4 in storage + 1 in the output register
        for (int i = 0; i < 5; i++) push_entry(32'hBEEF_0000 + 32'(i));
        repeat (8) step();
        check("occ_five", 32'(rd_count), 32'd5);
        deq_if.deq_rdy = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 deq_if.deq_rdy = 1'b0;
        repeat (3) step();
        check("occ_three", 32'(rd_count), 32'd3);
        drain("occ_drain");
        check("occ_zero", 32'(rd_count), 32'd0);
        deq_if.deq_rdy = 1'b0;
`endif

        // write pointer advances again after reset: data flows
        push_entry(32'h1234_5678);
        drain("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
